// File: rtl/ibex_fpu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ibex_fpu_seq_ctrl
//
// Sequencer in front of the combinational FPU datapath. It accepts one FP op
// per req valid/ready handshake and holds the op, rounding mode, rd and
// operands stable toward the FPU for a per-class number of cycles. On the last
// cycle it samples the FPU result into a writeback register and presents it on
// a valid/ready writeback port. Only one op is outstanding. flush_i kills
// whatever is in flight.
//
// Latency classes (req_class_i):
//   0 misc, 1 add/sub, 2 mul, 3 div, 4 sqrt, 5 mac, 6 conv, 7 misc.
//   A latency parameter of 0 is treated as 1.
//
// Configuration macro:
//   FPU_SEQ_B2B_EN  when defined, a new request may be accepted in the same
//                   cycle as the writeback handshake and goes straight to
//                   EXEC. When undefined, requests are accepted only in IDLE.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake
//   req_op_i, req_class_i, req_rm_i, req_rd_i
//   req_rs1_i, req_rs2_i, req_rs3_i, req_rs1_int_i
//                                 request fields, captured on accept
//   fpu_op_o ... fpu_rs1_int_o    held copies driven into the FPU
//   fpu_fp_we_i, fpu_fp_wdata_i, fpu_int_we_i, fpu_int_wdata_i
//                                 FPU result outputs
//   wb_valid_o / wb_ready_i       writeback handshake
//   wb_int_o, wb_addr_o, wb_data_o writeback target, register and data
//   flush_i                       abort in-flight op
//   busy_o                        sequencer not idle
// ----------------------------------------------------------------------------
module ibex_fpu_seq_ctrl #(
  parameter int OP_W     = 6,
  parameter int LAT_MISC = 1,
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 8,
  parameter int LAT_SQRT = 8,
  parameter int LAT_MAC  = 4,
  parameter int LAT_CONV = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [OP_W-1:0] req_op_i,
  input  logic [2:0]      req_class_i,
  input  logic [2:0]      req_rm_i,
  input  logic [4:0]      req_rd_i,
  input  logic [31:0]     req_rs1_i,
  input  logic [31:0]     req_rs2_i,
  input  logic [31:0]     req_rs3_i,
  input  logic [31:0]     req_rs1_int_i,
  output logic [OP_W-1:0] fpu_op_o,
  output logic [2:0]      fpu_rm_o,
  output logic [4:0]      fpu_rd_o,
  output logic [31:0]     fpu_rs1_o,
  output logic [31:0]     fpu_rs2_o,
  output logic [31:0]     fpu_rs3_o,
  output logic [31:0]     fpu_rs1_int_o,
  input  logic            fpu_fp_we_i,
  input  logic [31:0]     fpu_fp_wdata_i,
  input  logic            fpu_int_we_i,
  input  logic [31:0]     fpu_int_wdata_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic            wb_int_o,
  output logic [4:0]      wb_addr_o,
  output logic [31:0]     wb_data_o,
  input  logic            flush_i,
  output logic            busy_o
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             sample;

  // Remaining-cycle count loaded on accept: latency minus one, where a
  // configured latency of 0 still holds the operands for one cycle.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [2:0] cls);
    int l;
    case (cls)
      3'd1:    l = LAT_ADD;
      3'd2:    l = LAT_MUL;
      3'd3:    l = LAT_DIV;
      3'd4:    l = LAT_SQRT;
      3'd5:    l = LAT_MAC;
      3'd6:    l = LAT_CONV;
      default: l = LAT_MISC;
    endcase
    if (l < 1) l = 1;
    return CNT_W'(l - 1);
  endfunction

`ifdef FPU_SEQ_B2B_EN
  assign req_ready_o = ~flush_i & ((state_q == IDLE) | ((state_q == WB) & wb_ready_i));
`else
  assign req_ready_o = ~flush_i & (state_q == IDLE);
`endif

  assign accept = req_valid_i & req_ready_o;
  // Last EXEC cycle: FPU outputs are valid for the held operands.
  assign sample = (state_q == EXEC) & (cnt_q == '0) & ~flush_i;

  assign wb_valid_o = (state_q == WB);
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == '0) begin
          // An op that writes neither regfile retires without a writeback.
          if (fpu_fp_we_i | fpu_int_we_i) state_d = WB;
          else                            state_d = IDLE;
        end
      end
      WB: begin
        if (wb_ready_i) state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush beats every other transition, including a writeback handshake.
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)                               cnt_q <= lat_m1(req_class_i);
      else if ((state_q == EXEC) && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Operand hold registers: they change only on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpu_op_o      <= '0;
      fpu_rm_o      <= '0;
      fpu_rd_o      <= '0;
      fpu_rs1_o     <= '0;
      fpu_rs2_o     <= '0;
      fpu_rs3_o     <= '0;
      fpu_rs1_int_o <= '0;
    end else if (accept) begin
      fpu_op_o      <= req_op_i;
      fpu_rm_o      <= req_rm_i;
      fpu_rd_o      <= req_rd_i;
      fpu_rs1_o     <= req_rs1_i;
      fpu_rs2_o     <= req_rs2_i;
      fpu_rs3_o     <= req_rs3_i;
      fpu_rs1_int_o <= req_rs1_int_i;
    end
  end

  // Writeback register: an FP write takes priority over an integer write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_int_o  <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
    end else if (sample && (fpu_fp_we_i || fpu_int_we_i)) begin
      wb_addr_o <= fpu_rd_o;
      if (fpu_fp_we_i) begin
        wb_int_o  <= 1'b0;
        wb_data_o <= fpu_fp_wdata_i;
      end else begin
        wb_int_o  <= 1'b1;
        wb_data_o <= fpu_int_wdata_i;
      end
    end
  end

endmodule
